// File: rtl/irq_pending_ctrl_pkg.sv
// Shared constants and FSM encoding for the interrupt pending controller.
package irq_pending_ctrl_pkg;

    localparam int IRQ_MAX  = 16;
    localparam int IRQ_ID_W = 4;

    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_REQ     = 2'd1,
        IRQ_SERVICE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_pending_ctrl_prio_select.sv
// Combinational priority picker: highest set bit of a zero-padded 16-bit vector.
module irq_prio_select
    import irq_pending_ctrl_pkg::*;
(
    input  logic [IRQ_MAX-1:0]  eligible_i,
    output logic [IRQ_ID_W-1:0] index_o,
    output logic                any_o
);

    // Ascending scan so the last (highest) set bit overrides lower ones.
    always_comb begin
        index_o = '0;
        any_o   = 1'b0;
        for (int i = 0; i < IRQ_MAX; i++) begin
            if (eligible_i[i]) begin
                index_o = IRQ_ID_W'(i);
                any_o   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Interrupt front-end: synchronise, capture pending, mask, prioritise, handshake.
// Define IRQ_EDGE_DETECT_EN for edge capture; level capture otherwise.
module irq_pending_ctrl
    import irq_pending_ctrl_pkg::*;
#(
    parameter int NUM_IRQ     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_IRQ-1:0]  irq_in,
    input  logic                mask_we,
    input  logic [NUM_IRQ-1:0]  mask_wdata,
    output logic [NUM_IRQ-1:0]  mask_q,
    output logic [NUM_IRQ-1:0]  pending_q,
    output logic                irq_valid,
    output logic [IRQ_ID_W-1:0] irq_id,
    input  logic                irq_ack,
    input  logic                eoi,
    output logic                busy
);

    logic [NUM_IRQ-1:0]  sync_stage_q [SYNC_STAGES];
    logic [NUM_IRQ-1:0]  sync_q;
    logic [NUM_IRQ-1:0]  capture;
    logic [NUM_IRQ-1:0]  mask_d;
    logic [NUM_IRQ-1:0]  pending_d;
    logic [IRQ_MAX-1:0]  elig16;
    logic [IRQ_MAX-1:0]  live16;
    logic [IRQ_MAX-1:0]  clr16;
    logic [IRQ_ID_W-1:0] sel_idx;
    logic                sel_any;
    logic                ack_fire;

    irq_state_e          state_q;
    logic                valid_q;
    logic [IRQ_ID_W-1:0] id_q;
    logic                busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_stage_q[s] <= '0;
        end else begin
            sync_stage_q[0] <= irq_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_stage_q[s] <= sync_stage_q[s-1];
        end
    end

    assign sync_q = sync_stage_q[SYNC_STAGES-1];

`ifdef IRQ_EDGE_DETECT_EN
    logic [NUM_IRQ-1:0] sync_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_d <= '0;
        else     sync_d <= sync_q;
    end

    assign capture = sync_q & ~sync_d;
`else
    assign capture = sync_q;
`endif

    assign mask_d   = mask_we ? mask_wdata : mask_q;
    assign ack_fire = irq_ack && (state_q == IRQ_REQ);
    assign clr16    = ack_fire ? (IRQ_MAX'(1) << id_q) : '0;

    // Capture is OR-ed in after the clear, so a same-edge set beats the ack clear.
    assign pending_d = (pending_q & ~clr16[NUM_IRQ-1:0]) | capture;

    always_comb begin
        elig16 = '0;
        live16 = '0;
        elig16[NUM_IRQ-1:0] = pending_q & mask_q;
        live16[NUM_IRQ-1:0] = pending_q & mask_d;
    end

    irq_prio_select u_prio (
        .eligible_i (elig16),
        .index_o    (sel_idx),
        .any_o      (sel_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q    <= '0;
            pending_q <= '0;
        end else begin
            mask_q    <= mask_d;
            pending_q <= pending_d;
        end
    end

    // The REQ withdraw check looks at the mask being written this edge, so ack still wins a tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IRQ_IDLE;
            valid_q <= 1'b0;
            id_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IRQ_IDLE: begin
                    if (sel_any) begin
                        state_q <= IRQ_REQ;
                        valid_q <= 1'b1;
                        id_q    <= sel_idx;
                    end
                end
                IRQ_REQ: begin
                    if (irq_ack) begin
                        state_q <= IRQ_SERVICE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end else if (!live16[id_q]) begin
                        state_q <= IRQ_IDLE;
                        valid_q <= 1'b0;
                    end
                end
                IRQ_SERVICE: begin
                    if (eoi) begin
                        state_q <= IRQ_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IRQ_IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign irq_valid = valid_q;
    assign irq_id    = id_q;
    assign busy      = busy_q;

endmodule

// File: doc/irq_pending_ctrl.md
Name: irq_pending_ctrl

Overview:
- Interrupt front-end for the core: synchronises raw interrupt lines and captures them into a pending register.
- Applies a software mask.
- Picks the highest-index eligible line and presents it to the trap logic over a valid/ack handshake, followed by an end-of-interrupt (EOI) phase.
- Sits directly upstream of the trap-entry logic and feeds the priority-select stage with the masked pending vector.

Parameters:
- NUM_IRQ, 16, number of interrupt lines; legal range 2..16; unused upper bits of the 16-bit select vector are tied 0.
- SYNC_STAGES, 2, flops in each input synchroniser; legal range 1..3.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- irq_in  in  NUM_IRQ  raw interrupt lines, may be asynchronous.
- mask_we  in  1  mask write strobe.
- mask_wdata  in  NUM_IRQ  new mask; 1 = enabled.
- mask_q  out  NUM_IRQ  current mask.
- pending_q  out  NUM_IRQ  current pending register.
- irq_valid  out  1  request to trap logic.
- irq_id  out  4  index of the requested line; zero-extended.
- irq_ack  in  1  trap logic accepts irq_id.
- eoi  in  1  handler finished.
- busy  out  1  high in SERVICE state.

Behaviour:
- Reset (async, rst=1):
  - Synchroniser flops, edge register, pending_q, mask_q all 0.
  - State IDLE; irq_valid=0, irq_id=0, busy=0.
  - Reset asserted mid-handshake discards any in-flight request; nothing is remembered.
- Sync: each line passes through SYNC_STAGES flops giving sync_q; sync_d is sync_q delayed one cycle.
- Capture: pending[i] is set when sync_q[i] & ~sync_d[i] (edge mode; see Optional Feature).
- Latency: with an empty mask-enabled controller in IDLE, irq_valid rises on the (SYNC_STAGES+2)th rising clk edge after irq_in is first sampled high.
  - SYNC_STAGES=2 gives 4 edges.
- Eligibility:
  - eligible = pending_q & mask_q.
  - Selected index = highest set bit of eligible; index NUM_IRQ-1 has top priority.
- Mask: mask_we loads mask_wdata at the clock edge. Masking never clears pending bits.
- FSM:
  - IDLE:
    - irq_valid=0.
    - If eligible != 0, go to REQ next edge and latch the selected index into irq_id.
  - REQ:
    - irq_valid=1; irq_id held stable while in REQ, even if a higher line becomes eligible.
    - On irq_ack: clear pending[irq_id] and go to SERVICE.
    - If, without ack, the latched line is no longer eligible (mask write cleared it), return to IDLE with irq_valid=0 next edge.
    - irq_ack on the same edge as that mask write: ack wins.
  - SERVICE:
    - irq_valid=0, busy=1, irq_id retains its value.
    - On eoi: go to IDLE. New selection may start on the following edge.
- Ignored inputs: irq_ack outside REQ and eoi outside SERVICE have no effect.
- Simultaneous set/clear: if a new capture for bit i occurs on the same edge as the ack clearing bit i, set wins and pending[i] stays 1.
- Repeated edges: multiple edges on a line while it is already pending coalesce into one pending bit.
- Width: irq_id is 4 bits regardless of NUM_IRQ. Index arithmetic is unsigned.

Optional Feature:
- Macro: IRQ_EDGE_DETECT_EN.
- Defined: edge mode. pending[i] is set only on a rising edge of sync_q[i]; a line held high produces exactly one pending event.
- Undefined: level mode.
  - sync_d is not built; pending[i] is set every cycle sync_q[i]=1.
  - A line still high after ack re-pends on the next edge.
  - Latency is unchanged.

Decomposition:
- Shared package holds:
  - constants IRQ_MAX=16 and IRQ_ID_W=4;
  - FSM state encoding IRQ_IDLE=2'd0, IRQ_REQ=2'd1, IRQ_SERVICE=2'd2.
- One sub-module, irq_prio_select: purely combinational.
  - Input: 16-bit eligible vector, zero-padded.
  - Outputs: 4-bit index and an any flag.
  - Priority is highest index first; all-zero input gives index 0, any=0.
- Synchronisers, pending register and FSM stay in the top module.

Test Plan:
- Reset, mask=16'hFFFF, pulse irq_in[5] for 1 cycle (edge mode, SYNC_STAGES=2) -> irq_valid=1 at 4th edge, irq_id=5; ack -> pending_q[5]=0, busy=1; eoi -> IDLE, irq_valid stays 0.
- Raise irq_in[3] and irq_in[12] together -> irq_id=12 first; after ack+eoi -> irq_id=3.
- Mask=16'h0000, pulse irq_in[7] -> pending_q=16'h0080, irq_valid=0; write mask=16'h0080 -> irq_valid rises on next edge, irq_id=7.
- In REQ with irq_id=9, write mask=16'h0000 with no ack -> irq_valid=0 next edge, pending_q[9] still 1; repeat with ack on the same edge -> SERVICE, pending_q[9]=0.
- In REQ for line 4, new edge on line 4 lands on the ack edge -> pending_q[4]=1 after ack; after eoi -> line 4 requested again.
- Assert rst asynchronously mid-SERVICE -> all outputs 0 immediately, without waiting for clk; level mode (macro undefined) with irq_in[2] held high -> re-request after each eoi.
